// File: rtl/jtoutrun_rdrom_slot.sv
// Two-port road ROM responder: one-word cache per port, round-robin miss arbitration onto a single SDRAM read channel.
// Optional watchdog on stalled SDRAM reads: define JTOUTRUN_RDROM_WDOG_EN.

module jtoutrun_rdrom_entry #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_tag_i,
  input  logic [15:0]   wr_data_i,
  output logic          hit_o,
  output logic [15:0]   dout_o
);
  logic [AW-1:0] tag_q;
  logic [15:0]   data_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      tag_q   <= wr_tag_i;
      data_q  <= wr_data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = cs_i & valid_q & (addr_i == tag_q);
  assign dout_o = data_q;
endmodule

module jtoutrun_rdrom_slot #(
  parameter int          AW      = 14,
  parameter logic [21:0] OFFSET0 = 22'h0,
  parameter logic [21:0] OFFSET1 = 22'h4000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic [15:0]   slot0_dout,
  output logic          slot0_ok,
  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic [15:0]   slot1_dout,
  output logic          slot1_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   data_read
`ifdef JTOUTRUN_RDROM_WDOG_EN
  ,output logic         wdog_err
`endif
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  logic [NP-1:0]         cs, hit, miss, wr_en;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][15:0]   dout;
  logic [NP-1:0][21:0]   offs;

  state_t        state_q;
  logic          port_q, last_q, req_q;
  logic [AW-1:0] req_addr_q;
  logic [21:0]   saddr_q;

  logic          sel, done, timeout;
  logic [15:0]   wr_data;

  assign cs   = {slot1_cs, slot0_cs};
  assign addr = {slot1_addr, slot0_addr};
  assign offs = {OFFSET1, OFFSET0};

  for (genvar g = 0; g < NP; g++) begin : g_ent
    jtoutrun_rdrom_entry #(.AW(AW)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_i      (cs[g]),
      .addr_i    (addr[g]),
      .wr_en_i   (wr_en[g]),
      .wr_tag_i  (req_addr_q),
      .wr_data_i (wr_data),
      .hit_o     (hit[g]),
      .dout_o    (dout[g])
    );
  end

  assign miss = cs & ~hit;

  // Contention goes to the port that was not served last.
  always_comb begin
    sel = miss[1];
    if (&miss) sel = ~last_q;
  end

  always_comb begin
    done = 1'b0;
    case (state_q)
      REQ:     done = sdram_ack & sdram_dst;
      WAIT:    done = sdram_dst;
      default: done = 1'b0;
    endcase
    wr_en   = (done | timeout) ? (NP'(1) << port_q) : '0;
    wr_data = timeout ? 16'h0000 : data_read;
  end

`ifdef JTOUTRUN_RDROM_WDOG_EN
  logic [7:0] wdog_q;
  logic       werr_q;

  assign timeout  = (state_q != IDLE) && (wdog_q == 8'hFF) && !done;
  assign wdog_err = werr_q;

  // Held at zero in IDLE, so every entry to REQ starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      werr_q <= 1'b0;
    end else begin
      if (state_q == IDLE)      wdog_q <= '0;
      else if (wdog_q != 8'hFF) wdog_q <= wdog_q + 8'd1;
      if (timeout)              werr_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      saddr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|miss) begin
          port_q     <= sel;
          req_addr_q <= addr[sel];
          saddr_q    <= offs[sel] + 22'(addr[sel]);
          req_q      <= 1'b1;
          state_q    <= REQ;
        end
        REQ, WAIT: begin
          if (done || timeout) begin
            req_q   <= 1'b0;
            last_q  <= port_q;
            state_q <= IDLE;
          end else if (state_q == REQ && sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slot0_ok   = hit[0];
  assign slot1_ok   = hit[1];
  assign slot0_dout = dout[0];
  assign slot1_dout = dout[1];
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;
endmodule

// File: doc/jtoutrun_rdrom_slot.md
# jtoutrun_rdrom_slot

SDRAM-side responder for the two road-engine ROM ports (`rd0_*`, `rd1_*`) of the Out Run video block. It answers each port's `cs`/`addr` → `data`/`ok` handshake from a one-word cache per port. On a miss it arbitrates a single SDRAM read channel between the two ports. It sits between the video top level and the SDRAM bank controller.

## Interface
**Parameters**
- `AW`, 14: requester word-address width.
- `OFFSET0`, 22'h0: SDRAM word base address for port 0.
- `OFFSET1`, 22'h4000: SDRAM word base address for port 1.

**Ports**
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `slot0_cs`  in  1  port-0 read request.
- `slot0_addr`  in  AW  port-0 word address.
- `slot0_dout`  out  16  port-0 data.
- `slot0_ok`  out  1  port-0 data valid for the current address.
- `slot1_cs`, `slot1_addr`, `slot1_dout`, `slot1_ok`: same as port 0, for port 1.
- `sdram_req`  out  1  read request to the bank controller.
- `sdram_addr`  out  22  SDRAM word address.
- `sdram_ack`  in  1  request accepted.
- `sdram_dst`  in  1  data strobe; `data_read` is valid while high.
- `data_read`  in  16  SDRAM read data.

## Operation
**Per-port cache entry**
- Each port keeps `tag[AW-1:0]`, `data[15:0]` and `valid`.
- Hit: `cs & valid & (addr == tag)`.
- `slotN_ok` = hit, combinational from the registers and the current inputs. It drops in the same cycle the address changes.
- `slotN_dout` = `data` register, always driven, including during a miss.

**Miss and arbitration**
- Miss: `cs & ~hit`.
- When both ports miss, the port not served last wins (round-robin pointer `last`).
- After reset `last` = 1, so port 0 wins first.

**FSM**
- IDLE
  - If any miss: latch `port`, latch `req_addr = slotN_addr`, drive `sdram_addr = OFFSETn + req_addr` (22-bit add, carry discarded), set `sdram_req`, go to REQ.
- REQ
  - `sdram_req` stays high until `sdram_ack` is sampled high, then it clears.
  - If `sdram_dst` is also high in that cycle, capture and go to IDLE.
  - Otherwise go to WAIT.
- WAIT
  - On `sdram_dst`: write `data <= data_read`, `tag <= req_addr`, `valid <= 1` for the latched port, update `last <= port`, go to IDLE.

**Boundary behaviour**
- A requester that changes address or drops `cs` during REQ or WAIT does not abort the transfer. The data is stored under the latched `req_addr`. A new miss is served from IDLE afterwards.
- `cs` low: no request is issued and the entry is retained.
- While a port's transfer is pending, its `valid` stays set, so an old hit on the stored address is still reported.
- `sdram_ack` or `sdram_dst` arriving in IDLE is ignored.
- Reset mid-transfer: the FSM returns to IDLE and all `valid` bits clear. A late `sdram_dst` arriving after reset is ignored.

## Timing
**Reset values**
- `sdram_req` = 0, `sdram_addr` = 0.
- `slotN_dout` = 0, `slotN_ok` = 0.
- `valid` = 0, `last` = 1, state = IDLE.

**Latency**
- Miss seen in cycle N (IDLE) → `sdram_req` and `sdram_addr` registered high at N+1.
- `sdram_req` falls one cycle after the `ack` sample.
- `sdram_dst` in cycle K → `ok` high and new `dout` at K+1.
- Best case with ack and dst together at N+1: `ok` at N+2.

**Throughput and stability**
- One outstanding SDRAM read at a time.
- `sdram_addr` is stable from `req` rising until `dst` is captured.

## Configuration
`JTOUTRUN_RDROM_WDOG_EN`
- **Defined:** an 8-bit watchdog counts cycles in REQ and WAIT and is cleared on entry to REQ.
  - At a count of 255 with no completion, the FSM forces IDLE and drops `sdram_req`.
  - The latched port receives `data = 16'h0000`, `tag = req_addr`, `valid = 1`, and `last` is updated.
  - Sticky output `wdog_err` (out, 1, reset 0) sets on timeout and clears only on reset.
- **Undefined:** no counter and no `wdog_err` port; the FSM waits indefinitely in REQ or WAIT.

## Test plan
- **Reset:** `rst_n` low with `slot0_cs`=1 → `sdram_req`=0 and `slot0_ok`=0 throughout reset.
- **Single miss:** `slot0_cs`=1, `addr`=14'h0123; controller acks 2 cycles later and raises `dst` 3 cycles after that with 16'hBEEF.
  - `sdram_addr` = 22'h000123.
  - `slot0_dout` = 16'hBEEF and `ok`=1 the cycle after `dst`.
  - Holding the same address gives no further `req`.
- **Contention:** both ports miss in the same cycle (port0 0x0010, port1 0x0020).
  - First request is 22'h000010, second is 22'h004020.
  - With both missing again, the next grant goes to port 0.
- **Address change mid-flight:** `slot1_addr` goes 0x0005 → 0x0006 during WAIT.
  - Data is stored with tag 0x0005 and `slot1_ok` stays 0.
  - A second request for 22'h004006 follows.
  - `ok`=1 after that request's `dst`.
- **Reset during WAIT, then late `dst`:** `sdram_dst` arrives after `rst_n` is released.
  - `valid` stays 0, `sdram_req` restarts from IDLE for the still-missing port, and no stale write occurs.
- **Watchdog (`JTOUTRUN_RDROM_WDOG_EN`):** `ack` is given but `dst` never arrives.
  - After 255 cycles `slot0_ok`=1 with `dout`=16'h0000 and `wdog_err`=1.
  - `wdog_err` stays 1 until reset.
